// File: rtl/ps2_key_table_if.sv
// Bundle of the PS/2 line inputs and the key-table / byte-stream outputs of ps2_key_table.
// The receiver takes the slave modport; whatever drives the PS/2 lines takes the master modport.
interface ps2_key_table_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] keycode1;
    logic [7:0] keycode2;
    logic [7:0] keycode3;
    logic [7:0] keycode4;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_err;
    logic       overflow;

    modport slave (
        input  ps2_clk, ps2_data,
        output keycode1, keycode2, keycode3, keycode4,
        output byte_valid, byte_data, frame_err, overflow
    );

    modport master (
        output ps2_clk, ps2_data,
        input  keycode1, keycode2, keycode3, keycode4,
        input  byte_valid, byte_data, frame_err, overflow
    );
endinterface

// File: rtl/ps2_key_table.sv
// PS/2 scan-code set 2 receiver with a 4-slot held-key table (F0 break / E0 extended prefixes).
// Optional macro PS2_PARITY_CHK_EN: reject frames whose data+parity bits have even parity.
module ps2_key_table #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 25000
) (
    input  logic         vga_clk,
    input  logic         sys_rst,
    ps2_key_table_if.slave bus
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t         state, state_nxt;
    logic [1:0]     clk_sync_p0, data_sync_p0;
    logic           filt_lvl;
    logic [FW-1:0]  filt_cnt;
    logic           fall, din;
    logic [TW-1:0]  to_cnt;
    logic           timeout;
    logic [2:0]     bit_cnt, bit_cnt_nxt;
    logic [7:0]     shreg, shreg_nxt;
    logic           stop_ok;
    logic           byte_vld_p1, byte_vld_nxt, frame_err_p1, frame_err_nxt;
    logic [7:0]     byte_p1, byte_nxt;
    logic [7:0]     slot [4];
    logic           brk, ext, overflow_p2;
    logic           hit, have_free;
    logic [1:0]     free_idx;
`ifdef PS2_PARITY_CHK_EN
    logic           par_bit, par_bit_nxt;
`endif

    // Stage 0: synchronizers and ps2_clk glitch filter
    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            clk_sync_p0  <= 2'b11;
            data_sync_p0 <= 2'b11;
            filt_lvl     <= 1'b1;
            filt_cnt     <= '0;
        end else begin
            clk_sync_p0  <= {clk_sync_p0[0], bus.ps2_clk};
            data_sync_p0 <= {data_sync_p0[0], bus.ps2_data};
            if (clk_sync_p0[1] != filt_lvl) begin
                if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                    filt_lvl <= clk_sync_p0[1];
                    filt_cnt <= '0;
                end else begin
                    filt_cnt <= filt_cnt + FW'(1);
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    assign fall    = filt_lvl && !clk_sync_p0[1] && (filt_cnt == FW'(FILTER_LEN - 1));
    assign din     = data_sync_p0[1];
    assign timeout = (state != IDLE) && (to_cnt == TW'(TIMEOUT));

`ifdef PS2_PARITY_CHK_EN
    assign stop_ok = din && (^{shreg, par_bit});
`else
    assign stop_ok = din;
`endif

    // Stage 1: frame FSM; a stop-bit edge produces byte_valid/frame_err one cycle later
    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            shreg        <= '0;
            to_cnt       <= '0;
            byte_vld_p1  <= 1'b0;
            frame_err_p1 <= 1'b0;
            byte_p1      <= '0;
`ifdef PS2_PARITY_CHK_EN
            par_bit      <= 1'b0;
`endif
        end else begin
            state        <= state_nxt;
            bit_cnt      <= bit_cnt_nxt;
            shreg        <= shreg_nxt;
            byte_vld_p1  <= byte_vld_nxt;
            frame_err_p1 <= frame_err_nxt;
            byte_p1      <= byte_nxt;
`ifdef PS2_PARITY_CHK_EN
            par_bit      <= par_bit_nxt;
`endif
            if (fall)
                to_cnt <= '0;
            else if (to_cnt != TW'(TIMEOUT))
                to_cnt <= to_cnt + TW'(1);
        end
    end

    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        shreg_nxt     = shreg;
        byte_vld_nxt  = 1'b0;
        frame_err_nxt = 1'b0;
        byte_nxt      = byte_p1;
`ifdef PS2_PARITY_CHK_EN
        par_bit_nxt   = par_bit;
`endif
        // A stalled frame is abandoned even if an edge lands on the same cycle.
        if (timeout) begin
            state_nxt     = IDLE;
            frame_err_nxt = 1'b1;
        end else if (fall) begin
            case (state)
                IDLE: begin
                    if (!din) begin
                        state_nxt   = DATA;
                        bit_cnt_nxt = '0;
                    end else begin
                        frame_err_nxt = 1'b1;
                    end
                end
                DATA: begin
                    shreg_nxt   = {din, shreg[7:1]};
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7)
                        state_nxt = PARITY;
                end
                PARITY: begin
`ifdef PS2_PARITY_CHK_EN
                    par_bit_nxt = din;
`endif
                    state_nxt = STOP;
                end
                STOP: begin
                    state_nxt = IDLE;
                    if (stop_ok) begin
                        byte_vld_nxt = 1'b1;
                        byte_nxt     = shreg;
                    end else begin
                        frame_err_nxt = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Lowest empty slot wins, hence the descending scan.
    always_comb begin
        hit       = 1'b0;
        have_free = 1'b0;
        free_idx  = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (slot[i] == byte_p1)
                hit = 1'b1;
            if (slot[i] == 8'h00) begin
                have_free = 1'b1;
                free_idx  = 2'(i);
            end
        end
    end

    // Stage 2: byte decoder and held-key table
    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            for (int i = 0; i < 4; i++) slot[i] <= 8'h00;
            brk         <= 1'b0;
            ext         <= 1'b0;
            overflow_p2 <= 1'b0;
        end else begin
            overflow_p2 <= 1'b0;
            if (byte_vld_p1) begin
                case (byte_p1)
                    8'hF0: brk <= 1'b1;
                    8'hE0: ext <= 1'b1;
                    8'hAA: begin
                        for (int i = 0; i < 4; i++) slot[i] <= 8'h00;
                        brk <= 1'b0;
                        ext <= 1'b0;
                    end
                    8'hFA, 8'hFE, 8'hEE, 8'h00: ;
                    default: begin
                        brk <= 1'b0;
                        ext <= 1'b0;
                        if (!ext) begin
                            if (brk) begin
                                for (int i = 0; i < 4; i++)
                                    if (slot[i] == byte_p1) slot[i] <= 8'h00;
                            end else if (!hit) begin
                                if (have_free)
                                    slot[free_idx] <= byte_p1;
                                else
                                    overflow_p2 <= 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign bus.keycode1   = slot[0];
    assign bus.keycode2   = slot[1];
    assign bus.keycode3   = slot[2];
    assign bus.keycode4   = slot[3];
    assign bus.byte_valid = byte_vld_p1;
    assign bus.byte_data  = byte_p1;
    assign bus.frame_err  = frame_err_p1;
    assign bus.overflow   = overflow_p2;
endmodule

// File: tb/tb_ps2_key_table.sv
// Self-checking bench for ps2_key_table: directed scenarios plus random scan-code traffic
// compared against a behavioural key-table model.
module tb_ps2_key_table;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ps2_key_table_if bus();

    ps2_key_table dut (
        .vga_clk (clk),
        .sys_rst (rst),
        .bus     (bus)
    );

`ifdef PS2_PARITY_CHK_EN
    localparam bit PCHK = 1'b1;
`else
    localparam bit PCHK = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    int         bv_cnt = 0, fe_cnt = 0, ov_cnt = 0;
    logic [7:0] last_byte = 8'h00, kc_at1 = 8'h00, kc_next1 = 8'h00;
    bit         pend = 1'b0;

    logic [7:0] exp_kc [4];
    bit         m_brk, m_ext;

    // Output pulse monitor
    always @(negedge clk) begin
        if (pend) begin
            kc_next1 = bus.keycode1;
            pend     = 1'b0;
        end
        if (bus.byte_valid === 1'b1) begin
            bv_cnt++;
            last_byte = bus.byte_data;
            kc_at1    = bus.keycode1;
            pend      = 1'b1;
        end
        if (bus.frame_err === 1'b1) fe_cnt++;
        if (bus.overflow === 1'b1) ov_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [7:0] dut_kc(input int i);
        case (i)
            0:       return bus.keycode1;
            1:       return bus.keycode2;
            2:       return bus.keycode3;
            default: return bus.keycode4;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) exp_kc[i] = 8'h00;
        m_brk = 1'b0;
        m_ext = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b, output bit ov);
        bit present, placed;
        ov = 1'b0;
        if (b == 8'hF0) m_brk = 1'b1;
        else if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hAA) model_reset();
        else if (b == 8'hFA || b == 8'hFE || b == 8'hEE || b == 8'h00) begin end
        else begin
            if (!m_ext) begin
                if (m_brk) begin
                    for (int i = 0; i < 4; i++) if (exp_kc[i] == b) exp_kc[i] = 8'h00;
                end else begin
                    present = 1'b0;
                    for (int i = 0; i < 4; i++) if (exp_kc[i] == b) present = 1'b1;
                    if (!present) begin
                        placed = 1'b0;
                        for (int i = 0; i < 4; i++)
                            if (!placed && exp_kc[i] == 8'h00) begin
                                exp_kc[i] = b;
                                placed    = 1'b1;
                            end
                        ov = !placed;
                    end
                end
            end
            m_brk = 1'b0;
            m_ext = 1'b0;
        end
    endtask

    task automatic check_table(input string tag);
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s keycode%0d", tag, i + 1), {24'h0, dut_kc(i)}, {24'h0, exp_kc[i]});
    endtask

    task automatic ps2_bit(input logic b);
        bus.ps2_data = b;
        cyc(12);
        bus.ps2_clk = 1'b0;
        cyc(12);
        bus.ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        ps2_bit(!bad_stop);
        bus.ps2_data = 1'b1;
        cyc(30);
    endtask

    task automatic frame_chk(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        int  bv0, fe0, ov0;
        bit  acc, ov;
        string tag;
        tag = $sformatf("frame %02h", b);
        bv0 = bv_cnt; fe0 = fe_cnt; ov0 = ov_cnt;
        send_frame(b, bad_par, bad_stop);
        acc = !bad_stop && !(bad_par && PCHK);
        ov  = 1'b0;
        if (acc) model_byte(b, ov);
        chk({tag, " byte_valid"}, bv_cnt - bv0, {31'h0, acc});
        if (acc) chk({tag, " byte_data"}, {24'h0, last_byte}, {24'h0, b});
        chk({tag, " frame_err"}, fe_cnt - fe0, {31'h0, !acc});
        chk({tag, " overflow"}, ov_cnt - ov0, {31'h0, ov});
        check_table(tag);
    endtask

    task automatic xfer(input logic [7:0] b);
        frame_chk(b, 1'b0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check_table(tag);
        chk({tag, " byte_data"}, {24'h0, bus.byte_data}, 32'h0);
        chk({tag, " byte_valid"}, {31'h0, bus.byte_valid}, 32'h0);
        chk({tag, " frame_err"}, {31'h0, bus.frame_err}, 32'h0);
        chk({tag, " overflow"}, {31'h0, bus.overflow}, 32'h0);
    endtask

    initial begin
        int bv0, fe0;
        logic [7:0] rb;
        logic [7:0] pool [12];
        pool = '{8'h1D, 8'h1B, 8'h44, 8'h4B, 8'h29, 8'h75, 8'hF0, 8'hF0,
                 8'hE0, 8'hFA, 8'h00, 8'hAA};

        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        model_reset();
        cyc(3);
        for (int i = 0; i < 4; i++) exp_kc[i] = 8'h00;
        check_all_zero("reset");
        rst = 1'b0;
        cyc(5);

        // First key and pipeline latency
        xfer(8'h1D);
        chk("latency keycode1 at byte_valid", {24'h0, kc_at1}, 32'h00);
        chk("latency keycode1 one cycle later", {24'h0, kc_next1}, 32'h1D);

        // Fill table, overflow, typematic repeat
        xfer(8'h44); xfer(8'h1B); xfer(8'h4B); xfer(8'h29); xfer(8'h44);

        // Break in middle slot, then refill
        xfer(8'hF0); xfer(8'h44); xfer(8'h29);

        // Extended codes are discarded, self-test clears
        xfer(8'hE0); xfer(8'h75); xfer(8'hE0); xfer(8'hF0); xfer(8'h75);
        xfer(8'hAA);

        // Corrupted parity and stop bit
        xfer(8'h1D);
        frame_chk(8'h1B, 1'b1, 1'b0);
        frame_chk(8'h44, 1'b0, 1'b1);

        // Start bit of 1 in IDLE
        bv0 = bv_cnt; fe0 = fe_cnt;
        ps2_bit(1'b1);
        cyc(30);
        chk("bad start frame_err", fe_cnt - fe0, 32'd1);
        chk("bad start byte_valid", bv_cnt - bv0, 32'd0);

        // Stalled frame times out
        bv0 = bv_cnt; fe0 = fe_cnt;
        ps2_bit(1'b0);
        ps2_bit(1'b1); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
        bus.ps2_data = 1'b1;
        cyc(25100);
        chk("timeout frame_err", fe_cnt - fe0, 32'd1);
        chk("timeout byte_valid", bv_cnt - bv0, 32'd0);
        check_table("timeout");
        xfer(8'h4B);

        // Random scan-code traffic
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 15) < 12) rb = pool[$urandom_range(0, 10)];
            else rb = 8'($urandom_range(0, 255));
            if (rb == 8'hAA && $urandom_range(0, 3) != 0) rb = 8'h1B;
            xfer(rb);
        end
        xfer(8'hAA);
        xfer(8'h44);

        // Reset mid-frame
        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
        rst = 1'b1;
        cyc(1);
        model_reset();
        check_all_zero("midframe reset");
        rst = 1'b0;
        bus.ps2_data = 1'b1;
        cyc(30);
        xfer(8'h1B);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ps2_key_table.md
Name: ps2_key_table

Overview:
- PS/2 keyboard receiver feeding the game's key-state inputs.
- Deserializes scan-code set 2 frames from the keyboard and handles the F0 (break) and E0 (extended) prefixes.
- Maintains a 4-slot table of currently held keys, presented as keycode1..keycode4.
- The display/game logic matches these slots against paddle keys, e.g. 8'h1D/8'h1B (left paddle) and 8'h44/8'h4B (right paddle).

Parameters:
FILTER_LEN, 8, consecutive agreeing vga_clk samples required to change the filtered ps2_clk level
TIMEOUT, 25000, vga_clk cycles without a falling edge mid-frame before the frame is aborted (1 ms at 25 MHz)

Ports:
vga_clk  input  1  system clock; all logic on its rising edge
sys_rst  input  1  synchronous, active-high reset
ps2_clk  input  1  asynchronous PS/2 clock from the keyboard
ps2_data  input  1  asynchronous PS/2 data from the keyboard
keycode1  output  8  held-key slot 0; 8'h00 = empty
keycode2  output  8  held-key slot 1; 8'h00 = empty
keycode3  output  8  held-key slot 2; 8'h00 = empty
keycode4  output  8  held-key slot 3; 8'h00 = empty
byte_valid  output  1  one-cycle pulse when a good frame is received
byte_data  output  8  last good byte; held between pulses
frame_err  output  1  one-cycle pulse on bad start/stop/parity or timeout
overflow  output  1  one-cycle pulse when a make code is dropped because the table is full

Behaviour:
- Reset: one clock; synchronous, active-high reset. With sys_rst high at a vga_clk edge:
  - all keycodes = 8'h00; byte_data = 8'h00; byte_valid, frame_err, overflow = 0;
  - prefix flags cleared; FSM in IDLE; filter level = 1.
  - Reset mid-frame discards the partial frame.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-FF synchronizer.
  - ps2_clk is then filtered: the level changes only after FILTER_LEN consecutive equal samples.
  - Falling edge = filtered level 1->0. ps2_data is sampled (synchronized) on that cycle.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on an edge, data=0 -> DATA with bit count 0; data=1 -> stay IDLE, pulse frame_err.
  - DATA: shift in 8 bits LSB first; after the 8th bit -> PARITY.
  - PARITY: capture the bit; -> STOP.
  - STOP: require data=1 and odd parity over data+parity.
    - Good: byte_valid and byte_data valid on the next cycle.
    - Bad: frame_err pulse, no byte.
    - Either way -> IDLE.
- Timeout: a counter clears on every edge. If it reaches TIMEOUT in any state other than IDLE -> IDLE and frame_err pulse. The counter is saturating.
- Latency: stop-bit edge detected at cycle N -> byte_valid at N+1 -> table/keycodes updated at N+2.
- Byte decoder, applied on byte_valid:
  - 8'hF0 sets brk; 8'hE0 sets ext.
  - 8'hAA (self-test pass) clears all slots and flags.
  - 8'hFA, 8'hFE, 8'hEE, 8'h00 are ignored; flags are unchanged.
  - Any other byte is a key code, processed as below, then brk and ext are cleared.
  - If ext is set, the key code is discarded (table unchanged).
  - Make (brk=0):
    - if the code is already in a slot, no change (typematic repeat);
    - else write it to the lowest-index empty slot;
    - if all 4 slots are occupied, drop it and pulse overflow.
  - Break (brk=1): clear every slot equal to the code to 8'h00. A code not present is ignored.
  - Slots are never compacted; the remaining keys keep their positions.
- Duplicates never exist in the table.
- Simultaneous frame_err and timeout assert only one frame_err pulse.

Optional Feature:
- Macro PS2_PARITY_CHK_EN.
- Defined: a frame with even parity is rejected with a frame_err pulse, as in STOP above.
- Undefined: the parity bit is captured but ignored; only start/stop bits and timeout can raise frame_err.

Test Plan:
- Reset, then send frame 8'h1D (W) -> byte_valid pulse with byte_data=8'h1D; keycode1=8'h1D at N+2; others 8'h00.
- Make 1D, 44, 1B, 4B, then make 29 -> slots = 1D,44,1B,4B; overflow pulse; the repeated make of 44 changes nothing.
- With slots 1D,44,1B,4B: send F0 44, then make 29 -> keycode2 becomes 8'h00, then keycode2=8'h29; keycode1/3/4 unchanged.
- Send E0 75 then E0 F0 75 -> table unchanged, no overflow; send AA with keys held -> all slots 8'h00.
- Frame 8'h1D with a corrupted parity bit -> frame_err pulse, no byte_valid, table unchanged with PS2_PARITY_CHK_EN defined; accepted without it.
- Stop clocking after 4 data bits for more than 25000 cycles -> frame_err pulse, FSM in IDLE; the next full frame 8'h4B is received correctly. Assert sys_rst mid-frame -> all outputs 0.
